// File: rtl/cache_pkg.sv
// Shared types and address-field width helpers for the set-associative cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE_TAG,
        WRITE_BACK,
        ALLOCATE
    } state_t;

    function automatic int byte_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int word_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int data_w,
                                 input int words_per_line, input int sets);
        return addr_w - index_w(sets) - word_w(words_per_line) - byte_w(data_w);
    endfunction

    // A single-way cache still carries a 1-bit way number so ports never collapse to zero width.
    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU bookkeeping: one age counter per way per set, 0 = most recent.
module cache_lru
    import cache_pkg::*;
#(
    parameter int SETS = 64,
    parameter int WAYS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       touch,
    input  logic [index_w(SETS)-1:0]   touch_set,
    input  logic [way_w(WAYS)-1:0]     touch_way,
    input  logic [index_w(SETS)-1:0]   set,
    input  logic [WAYS-1:0]            valid,
    output logic [way_w(WAYS)-1:0]     victim
);

    localparam int WW = way_w(WAYS);

    logic [WW-1:0] age [SETS][WAYS];

    // Touch: ways younger than the touched one age by one, touched way becomes youngest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age[s][w] <= WW'(w);
        end else if (touch) begin
            for (int w = 0; w < WAYS; w++) begin
                if (touch_way == WW'(w))
                    age[touch_set][w] <= '0;
                else if (age[touch_set][w] < age[touch_set][touch_way])
                    age[touch_set][w] <= age[touch_set][w] + 1'b1;
            end
        end
    end

    // Victim: lowest invalid way, otherwise the oldest (ages are a permutation, so oldest = WAYS-1).
    always_comb begin
        logic found;
        victim = '0;
        found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!valid[w] && !found) begin
                victim = WW'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++)
                if (age[set][w] == WW'(WAYS - 1))
                    victim = WW'(w);
        end
    end

endmodule

// File: rtl/sa_cache_fsm.sv
// N-way set-associative write-back / write-allocate cache controller with hit/miss counters.
module sa_cache_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int SETS           = 64,
    parameter int WAYS           = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cpu_req_valid,
    input  logic                              cpu_req_rw,
    input  logic [ADDR_W-1:0]                 cpu_req_addr,
    input  logic [DATA_W-1:0]                 cpu_req_wdata,
    output logic                              cpu_res_ready,
    output logic [DATA_W-1:0]                 cpu_res_rdata,
    output logic                              mem_req_valid,
    output logic                              mem_req_rw,
    output logic [ADDR_W-1:0]                 mem_req_addr,
    output logic [DATA_W*WORDS_PER_LINE-1:0]  mem_req_wdata,
    input  logic                              mem_rsp_ready,
    input  logic [DATA_W*WORDS_PER_LINE-1:0]  mem_rsp_rdata,
    output logic [31:0]                       hit_count,
    output logic [31:0]                       miss_count
);

    localparam int LINE_W  = DATA_W * WORDS_PER_LINE;
    localparam int BYTE_W  = byte_w(DATA_W);
    localparam int WORD_W  = word_w(WORDS_PER_LINE);
    localparam int INDEX_W = index_w(SETS);
    localparam int TAG_W   = tag_w(ADDR_W, DATA_W, WORDS_PER_LINE, SETS);
    localparam int WAY_W   = way_w(WAYS);

    state_t              state;
    logic [ADDR_W-1:0]   req_addr;
    logic                req_rw;
    logic [DATA_W-1:0]   req_wdata;
    logic                first_cmp;
    logic [WAY_W-1:0]    vic_way;

    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAYS-1:0]     dirty_q [SETS];
    logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
    logic [LINE_W-1:0]   data_q  [SETS][WAYS];

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [WORD_W-1:0]   req_word;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    victim;
    logic [LINE_W-1:0]   hit_line;
    logic                unused_byte;

    assign req_tag     = req_addr[ADDR_W-1 -: TAG_W];
    assign req_index   = req_addr[BYTE_W+WORD_W +: INDEX_W];
    assign req_word    = req_addr[BYTE_W +: WORD_W];
    assign unused_byte = ^req_addr[BYTE_W-1:0];

    // Tag match across the ways of the addressed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_index][w] && tag_q[req_index][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hit_line = data_q[req_index][hit_way];

    cache_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
        .clk       (clk),
        .rst       (rst),
        .touch     (state == COMPARE_TAG && hit),
        .touch_set (req_index),
        .touch_way (hit_way),
        .set       (req_index),
        .valid     (valid_q[req_index]),
        .victim    (victim)
    );

    // CPU response and memory request are decoded from state so reset drops them without an edge.
    always_comb begin
        cpu_res_ready = (state == COMPARE_TAG) && hit;
        cpu_res_rdata = cpu_res_ready ? hit_line[req_word*DATA_W +: DATA_W] : '0;
        mem_req_valid = (state == WRITE_BACK) || (state == ALLOCATE);
        mem_req_rw    = (state == WRITE_BACK);
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        if (state == WRITE_BACK) begin
            mem_req_addr  = {tag_q[req_index][vic_way], req_index, {(WORD_W+BYTE_W){1'b0}}};
            mem_req_wdata = data_q[req_index][vic_way];
        end else if (state == ALLOCATE) begin
            mem_req_addr  = {req_tag, req_index, {(WORD_W+BYTE_W){1'b0}}};
        end
    end

    // Controller FSM: request capture, valid/dirty bookkeeping and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_addr   <= '0;
            req_rw     <= 1'b0;
            req_wdata  <= '0;
            first_cmp  <= 1'b0;
            vic_way    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req_valid) begin
                        req_addr  <= cpu_req_addr;
                        req_rw    <= cpu_req_rw;
                        req_wdata <= cpu_req_wdata;
                        first_cmp <= 1'b1;
                        state     <= COMPARE_TAG;
                    end
                end
                COMPARE_TAG: begin
                    if (hit) begin
                        if (req_rw)
                            dirty_q[req_index][hit_way] <= 1'b1;
                        // The re-compare after a fill finishes the request but is not a hit.
                        if (first_cmp)
                            hit_count <= hit_count + 32'd1;
                        state <= IDLE;
                    end else begin
                        miss_count <= miss_count + 32'd1;
                        first_cmp  <= 1'b0;
                        vic_way    <= victim;
                        state      <= (valid_q[req_index][victim] && dirty_q[req_index][victim])
                                      ? WRITE_BACK : ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    if (mem_rsp_ready)
                        state <= ALLOCATE;
                end
                ALLOCATE: begin
                    if (mem_rsp_ready) begin
                        valid_q[req_index][vic_way] <= 1'b1;
                        dirty_q[req_index][vic_way] <= 1'b0;
                        state <= COMPARE_TAG;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits guard their contents.
    always_ff @(posedge clk) begin
        if (state == COMPARE_TAG && hit && req_rw)
            data_q[req_index][hit_way][req_word*DATA_W +: DATA_W] <= req_wdata;
        if (state == ALLOCATE && mem_rsp_ready) begin
            data_q[req_index][vic_way] <= mem_rsp_rdata;
            tag_q[req_index][vic_way]  <= req_tag;
        end
    end

endmodule
